// File: rtl/parking_input_conditioner.sv
// Input conditioner for parking_system: debounces the gate sensors, captures a two-digit keypad
// password and times out abandoned entries. Define PARKING_LOCKOUT_EN to add the lockout feature.
module parking_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance_raw,
  input  logic       sensor_exit_raw,
  input  logic       key_valid,
  input  logic [1:0] key_digit,
  input  logic       key_clear,
  output logic       sensor_entrance,
  output logic       sensor_exit,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       pw_ready,
`ifdef PARKING_LOCKOUT_EN
  output logic       locked,
`endif
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_D1 = 3'd1,
    WAIT_D2 = 3'd2,
    READY   = 3'd3
`ifdef PARKING_LOCKOUT_EN
    ,
    LOCKED  = 3'd4
`endif
  } state_t;

  logic [1:0]       raw;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] deb_cnt_q [2];
  logic [CNT_W-1:0] deb_cnt_d [2];

  logic             ent_rise, exit_rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] tmo_inc;
  logic             tmo_expire;
  logic             timeout_hit;
  logic [1:0]       d1_q, d1_d;
  logic [1:0]       pw1_q, pw1_d;
  logic [1:0]       pw2_q, pw2_d;
  logic             pw_ready_q, pw_ready_d;
  logic             tmo_err_q, tmo_err_d;
`ifdef PARKING_LOCKOUT_EN
  logic [1:0]       fail_cnt_q, fail_cnt_d;
  logic             locked_q, locked_d;
`endif

  assign raw = {sensor_exit_raw, sensor_entrance_raw};

  // Index 0 is the entrance sensor, index 1 the exit sensor.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (raw[i] != deb_q[i]) begin
        if (deb_cnt_q[i] + CNT_ONE == DEB_LIMIT) begin
          deb_d[i] = raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
        end
      end
    end
    deb_prev_d = deb_q;
  end

  assign ent_rise  = deb_q[0] & ~deb_prev_q[0];
  assign exit_rise = deb_q[1] & ~deb_prev_q[1];

  assign tmo_inc    = (tmo_cnt_q == TMO_LIMIT) ? tmo_cnt_q : tmo_cnt_q + CNT_ONE;
  assign tmo_expire = (tmo_inc == TMO_LIMIT);

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    d1_d        = d1_q;
    pw1_d       = pw1_q;
    pw2_d       = pw2_q;
    pw_ready_d  = pw_ready_q;
    tmo_err_d   = 1'b0;
    timeout_hit = 1'b0;
`ifdef PARKING_LOCKOUT_EN
    fail_cnt_d  = fail_cnt_q;
    locked_d    = locked_q;
`endif

    case (state_q)
      IDLE: begin
        if (ent_rise) begin
          state_d   = WAIT_D1;
          tmo_cnt_d = '0;
          d1_d      = 2'd0;
        end
      end

      // A clear outranks a digit, and any key press outranks an expiring timer.
      WAIT_D1: begin
        if (key_clear) begin
          tmo_cnt_d = '0;
        end else if (key_valid) begin
          d1_d      = key_digit;
          state_d   = WAIT_D2;
          tmo_cnt_d = '0;
        end else if (tmo_expire) begin
          timeout_hit = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      WAIT_D2: begin
        if (key_clear) begin
          state_d   = WAIT_D1;
          d1_d      = 2'd0;
          tmo_cnt_d = '0;
        end else if (key_valid) begin
          state_d    = READY;
          pw1_d      = d1_q;
          pw2_d      = key_digit;
          pw_ready_d = 1'b1;
          tmo_cnt_d  = '0;
`ifdef PARKING_LOCKOUT_EN
          fail_cnt_d = 2'd0;
`endif
        end else if (tmo_expire) begin
          timeout_hit = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      READY: begin
        if (exit_rise) begin
          state_d    = IDLE;
          pw1_d      = 2'd0;
          pw2_d      = 2'd0;
          pw_ready_d = 1'b0;
          d1_d       = 2'd0;
        end
      end

`ifdef PARKING_LOCKOUT_EN
      LOCKED: begin
        if (tmo_expire) begin
          state_d    = IDLE;
          locked_d   = 1'b0;
          fail_cnt_d = 2'd0;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit) begin
      tmo_err_d = 1'b1;
      tmo_cnt_d = '0;
      d1_d      = 2'd0;
      state_d   = IDLE;
`ifdef PARKING_LOCKOUT_EN
      // The third consecutive abandoned entry locks the keypad; the lock timer reuses tmo_cnt.
      if (fail_cnt_q == 2'd2) begin
        state_d  = LOCKED;
        locked_d = 1'b1;
      end else begin
        fail_cnt_d = fail_cnt_q + 2'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
      state_q    <= IDLE;
      tmo_cnt_q  <= '0;
      d1_q       <= 2'd0;
      pw1_q      <= 2'd0;
      pw2_q      <= 2'd0;
      pw_ready_q <= 1'b0;
      tmo_err_q  <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
      fail_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
`endif
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      d1_q       <= d1_d;
      pw1_q      <= pw1_d;
      pw2_q      <= pw2_d;
      pw_ready_q <= pw_ready_d;
      tmo_err_q  <= tmo_err_d;
`ifdef PARKING_LOCKOUT_EN
      fail_cnt_q <= fail_cnt_d;
      locked_q   <= locked_d;
`endif
    end
  end

  assign sensor_entrance = deb_q[0];
  assign sensor_exit     = deb_q[1];
  assign password_1      = pw1_q;
  assign password_2      = pw2_q;
  assign pw_ready        = pw_ready_q;
  assign timeout_err     = tmo_err_q;
`ifdef PARKING_LOCKOUT_EN
  assign locked          = locked_q;
`endif

endmodule

// File: tb/tb_parking_input_conditioner.sv
// Self-checking bench for parking_input_conditioner: a cycle-indexed behavioural model is
// compared against the DUT after every clock edge, plus hand-computed literal expectations.
module tb_parking_input_conditioner;

   localparam int DEB = 4;
   localparam int TMO = 20;

   localparam int M_IDLE  = 0;
   localparam int M_W1    = 1;
   localparam int M_W2    = 2;
   localparam int M_READY = 3;
   localparam int M_LOCK  = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sensor_entrance_raw;
   logic       sensor_exit_raw;
   logic       key_valid;
   logic [1:0] key_digit;
   logic       key_clear;
   logic       sensor_entrance;
   logic       sensor_exit;
   logic [1:0] password_1;
   logic [1:0] password_2;
   logic       pw_ready;
   logic       timeout_err;
`ifdef PARKING_LOCKOUT_EN
   logic       locked;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: debounced levels, the last edge each raw input agreed with its output,
   // the password phase and the edge at which its timer was last restarted.
   logic       m_deb   [2];
   logic       m_prev  [2];
   int         m_agree [2];
   int         m_mode;
   int         m_since;
   int         m_fails;
   logic [1:0] m_d1;
   logic [1:0] m_pw1;
   logic [1:0] m_pw2;
   logic       m_tmo;

   parking_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (16)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .sensor_entrance_raw(sensor_entrance_raw),
      .sensor_exit_raw    (sensor_exit_raw),
      .key_valid          (key_valid),
      .key_digit          (key_digit),
      .key_clear          (key_clear),
      .sensor_entrance    (sensor_entrance),
      .sensor_exit        (sensor_exit),
      .password_1         (password_1),
      .password_2         (password_2),
      .pw_ready           (pw_ready),
`ifdef PARKING_LOCKOUT_EN
      .locked             (locked),
`endif
      .timeout_err        (timeout_err)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic compareVal(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Advance the model by one rising edge using the inputs sampled on that edge.
   task automatic modelStep();
      logic rise_ent;
      logic rise_ext;
      logic raw [2];
      cyc++;
      m_tmo = 1'b0;
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            m_deb[i]   = 1'b0;
            m_prev[i]  = 1'b0;
            m_agree[i] = cyc;
         end
         m_mode  = M_IDLE;
         m_since = cyc;
         m_fails = 0;
         m_d1    = 2'd0;
         m_pw1   = 2'd0;
         m_pw2   = 2'd0;
         return;
      end
      rise_ent = m_deb[0] & ~m_prev[0];
      rise_ext = m_deb[1] & ~m_prev[1];
      case (m_mode)
         M_IDLE: begin
            if (rise_ent) begin
               m_mode  = M_W1;
               m_since = cyc;
            end
         end
         M_W1, M_W2: begin
            if (key_clear) begin
               m_mode  = M_W1;
               m_since = cyc;
            end else if (key_valid && m_mode == M_W1) begin
               m_d1    = key_digit;
               m_mode  = M_W2;
               m_since = cyc;
            end else if (key_valid) begin
               m_pw1   = m_d1;
               m_pw2   = key_digit;
               m_mode  = M_READY;
               m_fails = 0;
            end else if (cyc - m_since >= TMO) begin
               m_tmo  = 1'b1;
               m_mode = M_IDLE;
`ifdef PARKING_LOCKOUT_EN
               m_fails++;
               if (m_fails == 3) begin
                  m_mode  = M_LOCK;
                  m_since = cyc;
                  m_fails = 0;
               end
`endif
            end
         end
         M_READY: begin
            if (rise_ext) m_mode = M_IDLE;
         end
         default: begin
            if (cyc - m_since >= TMO) m_mode = M_IDLE;
         end
      endcase
      raw[0] = sensor_entrance_raw;
      raw[1] = sensor_exit_raw;
      for (int i = 0; i < 2; i++) begin
         m_prev[i] = m_deb[i];
         if (raw[i] == m_deb[i]) begin
            m_agree[i] = cyc;
         end else if (cyc - m_agree[i] >= DEB) begin
            m_deb[i]   = raw[i];
            m_agree[i] = cyc;
         end
      end
   endtask

   task automatic checkOutput();
      logic ready;
      ready = (m_mode == M_READY);
      compareVal("sensor_entrance", sensor_entrance, m_deb[0]);
      compareVal("sensor_exit", sensor_exit, m_deb[1]);
      compareVal("pw_ready", pw_ready, ready);
      compareVal("password_1", password_1, ready ? m_pw1 : 2'd0);
      compareVal("password_2", password_2, ready ? m_pw2 : 2'd0);
      compareVal("timeout_err", timeout_err, m_tmo);
`ifdef PARKING_LOCKOUT_EN
      compareVal("locked", locked, m_mode == M_LOCK);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic ent, input logic ext, input logic kv,
                                input logic [1:0] kd, input logic kc);
      sensor_entrance_raw = ent;
      sensor_exit_raw     = ext;
      key_valid           = kv;
      key_digit           = kd;
      key_clear           = kc;
      tick();
      key_valid = 1'b0;
      key_clear = 1'b0;
   endtask

   task automatic hold(input int n);
      repeat (n) applyStimulus(sensor_entrance_raw, sensor_exit_raw, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic pressKey(input logic [1:0] d);
      applyStimulus(sensor_entrance_raw, sensor_exit_raw, 1'b1, d, 1'b0);
   endtask

   task automatic pressClear();
      applyStimulus(sensor_entrance_raw, sensor_exit_raw, 1'b0, 2'd0, 1'b1);
   endtask

   // Four raw-high edges debounce the entrance; the fifth edge is where the FSM acts on it.
   task automatic enterCar();
      repeat (DEB) applyStimulus(1'b1, sensor_exit_raw, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, sensor_exit_raw, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic exitCar();
      repeat (DEB) applyStimulus(sensor_entrance_raw, 1'b1, 1'b0, 2'd0, 1'b0);
      applyStimulus(sensor_entrance_raw, 1'b0, 1'b0, 2'd0, 1'b0);
      hold(DEB);
   endtask

   initial begin
      reset_n             = 1'b0;
      sensor_entrance_raw = 1'b0;
      sensor_exit_raw     = 1'b0;
      key_valid           = 1'b0;
      key_digit           = 2'd0;
      key_clear           = 1'b0;

      // Reset held with raw inputs toggling.
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
      compareVal("reset_sensor_entrance", sensor_entrance, 1'b0);
      compareVal("reset_sensor_exit", sensor_exit, 1'b0);
      compareVal("reset_pw_ready", pw_ready, 1'b0);
      compareVal("reset_timeout_err", timeout_err, 1'b0);
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      hold(3);
      compareVal("post_reset_entrance", sensor_entrance, 1'b0);
      pressKey(2'd1);
      pressKey(2'd2);
      compareVal("idle_ignores_keys", pw_ready, 1'b0);

      // Glitch of three edges, then a clean rise of four edges.
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      compareVal("glitch_filtered", sensor_entrance, 1'b0);
      hold(3);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      compareVal("entrance_after_3_edges", sensor_entrance, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      compareVal("entrance_after_4_edges", sensor_entrance, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

      // Password 1,2; a second entrance while READY is ignored; exit clears.
      pressKey(2'd1);
      pressKey(2'd2);
      compareVal("pw_ready_after_key2", pw_ready, 1'b1);
      compareVal("password_1_is_1", password_1, 2'd1);
      compareVal("password_2_is_2", password_2, 2'd2);
      enterCar();
      compareVal("ready_ignores_entrance", pw_ready, 1'b1);
      hold(DEB);
      repeat (DEB) applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
      compareVal("exit_debounced", sensor_exit, 1'b1);
      compareVal("ready_held_until_exit_rise", pw_ready, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      compareVal("exit_clears_pw_ready", pw_ready, 1'b0);
      compareVal("exit_clears_password_1", password_1, 2'd0);
      hold(DEB);

      // Clear discards a staged digit.
      enterCar();
      pressKey(2'd3);
      pressClear();
      pressKey(2'd0);
      pressKey(2'd2);
      compareVal("clear_password_1", password_1, 2'd0);
      compareVal("clear_password_2", password_2, 2'd2);
      exitCar();

      // Clear and digit together in WAIT_D1: the digit is dropped.
      enterCar();
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
      pressKey(2'd2);
      compareVal("clear_beats_key_still_waiting", pw_ready, 1'b0);
      pressKey(2'd3);
      compareVal("clear_beats_key_password_1", password_1, 2'd2);
      compareVal("clear_beats_key_password_2", password_2, 2'd3);
      exitCar();

      // Timeout after twenty idle edges in WAIT_D1.
      enterCar();
      hold(TMO - 1);
      compareVal("no_timeout_at_19", timeout_err, 1'b0);
      hold(1);
      compareVal("timeout_at_20", timeout_err, 1'b1);
      hold(1);
      compareVal("timeout_one_cycle", timeout_err, 1'b0);
      pressKey(2'd1);
      pressKey(2'd2);
      compareVal("idle_after_timeout", pw_ready, 1'b0);

      // A key on the expiring edge wins, and again in WAIT_D2.
      enterCar();
      hold(TMO - 1);
      pressKey(2'd3);
      compareVal("key_beats_timeout", timeout_err, 1'b0);
      hold(TMO - 1);
      pressKey(2'd1);
      compareVal("key_beats_timeout_d2", timeout_err, 1'b0);
      compareVal("late_pw_ready", pw_ready, 1'b1);
      compareVal("late_password_1", password_1, 2'd3);
      compareVal("late_password_2", password_2, 2'd1);
      exitCar();

      // Timeout from WAIT_D2.
      enterCar();
      pressKey(2'd2);
      hold(TMO - 1);
      compareVal("no_timeout_d2_at_19", timeout_err, 1'b0);
      hold(1);
      compareVal("timeout_d2_at_20", timeout_err, 1'b1);
      hold(2);

      // Reset in the middle of an entry aborts it silently.
      enterCar();
      pressKey(2'd1);
      reset_n = 1'b0;
      hold(1);
      reset_n = 1'b1;
      compareVal("reset_mid_no_timeout", timeout_err, 1'b0);
      hold(TMO + 5);
      compareVal("reset_mid_pw_ready", pw_ready, 1'b0);

`ifdef PARKING_LOCKOUT_EN
      // Third consecutive timeout locks for twenty edges; entrances are ignored meanwhile.
      repeat (2) begin
         enterCar();
         hold(TMO);
      end
      enterCar();
      hold(TMO);
      compareVal("lock_timeout_pulse", timeout_err, 1'b1);
      compareVal("locked_set", locked, 1'b1);
      enterCar();
      hold(TMO - 6);
      compareVal("locked_at_19", locked, 1'b1);
      hold(1);
      compareVal("unlocked_at_20", locked, 1'b0);
      hold(2);
      enterCar();
      pressKey(2'd1);
      pressKey(2'd2);
      compareVal("after_lock_pw_ready", pw_ready, 1'b1);
      compareVal("after_lock_password_2", password_2, 2'd2);
      exitCar();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
